// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and default configuration.
// Imported by the fetch FIFO and the fetch unit.
package fetch_unit_pkg;

  localparam int CFG_XLEN     = 32;
  localparam int CFG_ADDR_LEN = 8;

  localparam logic [CFG_XLEN-1:0] CFG_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [CFG_XLEN-1:0] instr;
    logic [CFG_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular skid buffer of fetched {instr, pc} entries.
// Depth need not be a power of two; flush wins over push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] occ
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (occ != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (do_push && !do_pop) begin
        occ <= occ + CW'(1);
      end else if (!do_push && do_pop) begin
        occ <= occ - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives iram, and feeds
// decode through a skid FIFO with redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                XLEN         = CFG_XLEN,
  parameter int                ADDR_LEN     = CFG_ADDR_LEN,
  parameter logic [XLEN-1:0]   RESET_VECTOR = CFG_RESET_VECTOR,
  parameter int                FIFO_DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] iram_addr,
  input  logic [XLEN-1:0]     iram_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                fetch_halt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            pop;
  logic            issue;
  logic [CW-1:0]   occ;
  logic [CW:0]     used;
  logic [CW:0]     room;
  fetch_entry_t    head;
  fetch_entry_t    din;

  assign iram_addr   = fetch_pc[ADDR_LEN+1:2];
  assign instr_valid = (occ != '0);
  assign pop         = instr_valid && instr_ready;

  // Count the word still in flight so a full FIFO is never pushed.
  assign used  = {1'b0, occ} + (CW+1)'(inflight);
  assign room  = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign issue = !redirect_valid && !fetch_halt && (used < room);

  assign din.instr = iram_data;
  assign din.pc    = inflight_pc;

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_VECTOR & PC_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & PC_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (inflight),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .occ   (occ)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(inflight && occ == CW'(FIFO_DEPTH)));
      assert (used <= (CW+1)'(FIFO_DEPTH));
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of iram.
- Owns the program counter and drives the iram word address every cycle.
- Captures iram's 1-cycle-latency read data, tags it with its PC, and presents it to decode over a valid/ready handshake.
- Absorbs decode back-pressure with a small skid FIFO. Branch/exception redirects flush all in-flight and buffered fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000: byte PC loaded on reset.
- FIFO_DEPTH, 2: fetch buffer entries. Minimum 2, which is required for 1 instr/cycle throughput.
- ADDR_LEN, cpu_config::ADDR_LEN: iram word-index width.
- XLEN, cpu_config::XLEN: instruction/PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- iram_addr  out  ADDR_LEN  word index to iram addr_a; equals fetch_pc[ADDR_LEN+1:2].
- iram_data  in  XLEN  iram data_out_a; valid the cycle after the address was presented.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  byte PC of instr.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new byte PC; bits [1:0] are ignored (forced to 0).
- fetch_halt  in  1  stop issuing new fetches; already-issued fetches still drain.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_VECTOR with low 2 bits cleared.
  - inflight=0, FIFO empty, instr_valid=0, instr=0, instr_pc=0.
  - iram_addr is combinational from fetch_pc, so it shows the RESET_VECTOR index during reset.
- Issue at cycle t:
  - Condition: issue = !redirect_valid && !fetch_halt && (occ + inflight - pop) < FIFO_DEPTH, where pop = instr_valid && instr_ready.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN).
  - With no issue, iram_addr still shows fetch_pc, but inflight<=0.
- Capture at t+1: if inflight, push {iram_data, inflight_pc} into the FIFO. iram has no enable, so iram_data is ignored whenever inflight=0.
- Output: FIFO head drives instr/instr_pc. instr_valid = (occ != 0).
  - Latency: address issued at t → instr_valid at t+2.
  - Steady-state throughput with instr_ready=1 is 1 instr/cycle.
- Handshake rules:
  - Once instr_valid=1, instr and instr_pc are held stable until pop or redirect.
  - instr_valid never depends combinationally on instr_ready.
- Redirect at cycle t (highest priority):
  - FIFO cleared, inflight<=0 (the returning word is discarded), fetch_pc<=redirect_pc&~3, no issue at t.
  - A pop in the same cycle t counts as accepted.
  - instr_valid=0 at t+1. First redirected fetch is issued at t+1 and is valid at t+3.
- Boundaries:
  - FIFO full: no push can occur, because the issue rule guarantees room; an overflow is a bug.
  - FIFO empty while ready=1: instr_valid=0.
  - Simultaneous push and pop: occ unchanged.
  - PC wrap from 32'hFFFF_FFFC goes to 0.
  - iram index wraps by truncation.
  - fetch_halt mid-stream: the in-flight word is still captured. Deasserting halt resumes at the next sequential PC.
  - Redirect during halt: fetch_pc updates, but nothing is issued until halt drops.
- Assertions (sim only): no push when occ==FIFO_DEPTH; occ+inflight ≤ FIFO_DEPTH.

Decomposition:
- cpu_types gains fetch_entry_t {logic[XLEN-1:0] instr; logic[XLEN-1:0] pc;}.
- RESET_VECTOR default lives in cpu_config.
- Sub-module fetch_fifo is a parameterised circular buffer of fetch_entry_t with flush, push, pop, occupancy and head outputs.
- Wrap pointers use mod FIFO_DEPTH and are not required to be a power of 2.
- fetch_unit contains the PC register, issue logic, inflight tracking and redirect control.

Test Plan:
- Reset with RESET_VECTOR=0, iram word i = 0x1000+i, instr_ready=1 → first instr_valid 2 cycles after the first post-reset edge, with instr=0x1000 and pc=0. Then pc 4, 8, 12… with instr 0x1001, 0x1002… every cycle, no gaps.
- Drop instr_ready for 5 cycles mid-stream at pc=0x10 → instr 0x1004 is held stable and occ never exceeds 2. After ready returns, the sequence continues 0x1005, 0x1006 with no drop or duplicate.
- FIFO full with ready=0, then pulse redirect_valid with redirect_pc=0x43 → instr_valid=0 next cycle. The next valid instr has pc=0x40 and instr=0x1010, and no pre-redirect word appears afterwards.
- Redirect in the same cycle as an accepted handshake → that instruction is consumed exactly once and the next output is the redirect target.
- RESET_VECTOR=32'hFFFF_FFFC with LINES=16 → pcs FFFF_FFFC, 0, 4 and iram_addr 15, 0, 1.
- Assert rst=0 asynchronously between clock edges mid-stream → instr_valid drops immediately, with no clock edge needed. After release, fetch restarts at RESET_VECTOR; fetch_halt=1 blocks this until it drops.
